noc_link_connector: RTL and testbench

NOC_LINK_CONNECTOR -- requirements
Module: noc_link_connector

---
 rtl/noc_link_connector.sv | 134 +++++++++++++
 tb/tb_noc_link_connector.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_link_connector.sv
//==============================================================================
// Module      : noc_link_connector
// Description : CH_NUM independent unidirectional flit FIFOs with valid/ready
//               handshakes. Optional per-channel framing checker compiled in by
//               defining NOC_LINK_ERR_CHK_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_link_connector #(
    parameter int CH_NUM = 4,
    parameter int DATA_W = `Noc_Data_Width,
    parameter int DEPTH  = 4
) (
    input  logic                                  noc_clk,
    input  logic                                  noc_rst,
    input  logic [CH_NUM-1:0]                     in_valid,
    output logic [CH_NUM-1:0]                     in_ready,
    input  logic [CH_NUM*DATA_W-1:0]              in_flit,
    input  logic [CH_NUM-1:0]                     in_is_header,
    input  logic [CH_NUM-1:0]                     in_is_tail,
    output logic [CH_NUM-1:0]                     out_valid,
    input  logic [CH_NUM-1:0]                     out_ready,
    output logic [CH_NUM*DATA_W-1:0]              out_flit,
    output logic [CH_NUM-1:0]                     out_is_header,
    output logic [CH_NUM-1:0]                     out_is_tail,
    output logic [CH_NUM*($clog2(DEPTH)+1)-1:0]   occupancy,
    input  logic [CH_NUM-1:0]                     err_clr,
    output logic [CH_NUM-1:0]                     proto_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int ENT_W = DATA_W + 2;

`ifdef NOC_LINK_ERR_CHK_EN
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } chk_state_t;
`endif

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        logic [ENT_W-1:0] r_mem [DEPTH];
        logic [PTR_W-1:0] r_wr_ptr;
        logic [PTR_W-1:0] r_rd_ptr;
        logic [OCC_W-1:0] r_count;
        logic             w_push;
        logic             w_pop;

        // Ready depends only on the stored count, so out_ready never reaches in_ready.
        assign in_ready[c]  = (r_count != OCC_W'(DEPTH));
        assign out_valid[c] = (r_count != '0);
        assign w_push       = in_valid[c] & in_ready[c];
        assign w_pop        = out_valid[c] & out_ready[c];

        assign {out_is_header[c], out_is_tail[c], out_flit[c*DATA_W +: DATA_W]} = r_mem[r_rd_ptr];
        assign occupancy[c*OCC_W +: OCC_W] = r_count;

        always_ff @(posedge noc_clk) begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {in_is_header[c], in_is_tail[c], in_flit[c*DATA_W +: DATA_W]};
            end
        end

        always_ff @(posedge noc_clk or posedge noc_rst) begin
            if (noc_rst) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end

`ifdef NOC_LINK_ERR_CHK_EN
        chk_state_t r_state;
        chk_state_t w_state_nxt;
        logic       w_err_set;
        logic       r_err;

        always_comb begin
            w_state_nxt = r_state;
            w_err_set   = 1'b0;
            if (w_push) begin
                if (in_is_header[c]) begin
                    // A header always (re)starts a packet; inside a packet it is also an error.
                    w_err_set   = (r_state == ST_IN_PKT);
                    w_state_nxt = in_is_tail[c] ? ST_IDLE : ST_IN_PKT;
                end else if (r_state == ST_IDLE) begin
                    w_err_set   = 1'b1;
                end else if (in_is_tail[c]) begin
                    w_state_nxt = ST_IDLE;
                end
            end
        end

        always_ff @(posedge noc_clk or posedge noc_rst) begin
            if (noc_rst) begin
                r_state <= ST_IDLE;
                r_err   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_err   <= w_err_set | (r_err & ~err_clr[c]);
            end
        end

        assign proto_err[c] = r_err;
`endif
    end

`ifndef NOC_LINK_ERR_CHK_EN
    logic w_unused_err_clr;
    assign w_unused_err_clr = ^err_clr;
    assign proto_err        = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_noc_link_connector.sv
//==============================================================================
// Module      : tb_noc_link_connector
// Description : Self-checking bench for noc_link_connector against a queue model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_noc_link_connector;

    localparam int CH = 4;
    localparam int DW = 8;
    localparam int D  = 4;
    localparam int OW = $clog2(D) + 1;
`ifdef NOC_LINK_ERR_CHK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic              noc_clk = 1'b0;
    logic              noc_rst;
    logic [CH-1:0]     in_valid, in_ready, in_is_header, in_is_tail;
    logic [CH*DW-1:0]  in_flit, out_flit;
    logic [CH-1:0]     out_valid, out_ready, out_is_header, out_is_tail;
    logic [CH*OW-1:0]  occupancy;
    logic [CH-1:0]     err_clr, proto_err;

    noc_link_connector #(.CH_NUM(CH), .DATA_W(DW), .DEPTH(D)) u_dut (
        .noc_clk(noc_clk), .noc_rst(noc_rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
        .in_is_header(in_is_header), .in_is_tail(in_is_tail),
        .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit),
        .out_is_header(out_is_header), .out_is_tail(out_is_tail),
        .occupancy(occupancy), .err_clr(err_clr), .proto_err(proto_err)
    );

    always #5 noc_clk = ~noc_clk;

    int errors = 0;
    int checks = 0;

    // Model: each entry is {header, tail, flit}
    logic [DW+1:0] mq[CH][$];
    bit            m_in_pkt[CH];
    bit            m_err[CH];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            mq[c].delete();
            m_in_pkt[c] = 1'b0;
            m_err[c]    = 1'b0;
        end
    endtask

    task automatic check_outputs();
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("in_ready[%0d]", c), 64'(in_ready[c]), 64'(mq[c].size() < D));
            chk($sformatf("out_valid[%0d]", c), 64'(out_valid[c]), 64'(mq[c].size() != 0));
            chk($sformatf("occupancy[%0d]", c), 64'(occupancy[c*OW +: OW]), 64'(mq[c].size()));
            chk($sformatf("proto_err[%0d]", c), 64'(proto_err[c]), 64'(ERR_EN & m_err[c]));
            if (mq[c].size() != 0) begin
                chk($sformatf("head[%0d]", c),
                    64'({out_is_header[c], out_is_tail[c], out_flit[c*DW +: DW]}), 64'(mq[c][0]));
            end
        end
    endtask

    // Check current outputs, then advance one clock and update the model.
    task automatic cycle();
        bit            pv[CH];
        bit            po[CH];
        bit            clr[CH];
        logic [DW+1:0] ent[CH];
        check_outputs();
        for (int c = 0; c < CH; c++) begin
            pv[c]  = in_valid[c] && (mq[c].size() < D);
            po[c]  = out_ready[c] && (mq[c].size() != 0);
            clr[c] = err_clr[c];
            ent[c] = {in_is_header[c], in_is_tail[c], in_flit[c*DW +: DW]};
        end
        @(posedge noc_clk);
        #1;
        for (int c = 0; c < CH; c++) begin
            bit set;
            set = 1'b0;
            if (po[c]) void'(mq[c].pop_front());
            if (pv[c]) begin
                mq[c].push_back(ent[c]);
                if (ent[c][DW+1]) begin
                    set         = m_in_pkt[c];
                    m_in_pkt[c] = !ent[c][DW];
                end else if (!m_in_pkt[c]) begin
                    set = 1'b1;
                end else if (ent[c][DW]) begin
                    m_in_pkt[c] = 1'b0;
                end
            end
            m_err[c] = set | (m_err[c] & !clr[c]);
        end
    endtask

    task automatic idle_inputs();
        in_valid = '0; in_flit = '0; in_is_header = '0; in_is_tail = '0;
        out_ready = '0; err_clr = '0;
    endtask

    task automatic drive(input int c, input logic [DW-1:0] f, input bit h, input bit t);
        in_valid[c]          = 1'b1;
        in_flit[c*DW +: DW]  = f;
        in_is_header[c]      = h;
        in_is_tail[c]        = t;
    endtask

    task automatic drain();
        idle_inputs();
        out_ready = '1;
        for (int i = 0; i < D + 1; i++) cycle();
        out_ready = '0;
    endtask

    logic [DW:0] got[$];
    int          idx;

    initial begin
        idle_inputs();
        model_reset();
        noc_rst = 1'b1;
        #23;
        check_outputs();
        @(posedge noc_clk);
        #3 noc_rst = 1'b0;
        @(posedge noc_clk);
        #1;
        check_outputs();

        // Fill ch0 with 5 flits while the sink stalls
        for (int i = 0; i < 5; i++) begin
            drive(0, DW'(8'h10 + i), i == 0, 1'b0);
            cycle();
        end
        chk("full_in_ready0", 64'(in_ready[0]), 64'd0);
        chk("full_occ0", 64'(occupancy[0 +: OW]), 64'd4);
        chk("full_occ_others", 64'(occupancy[CH*OW-1:OW]), 64'd0);
        chk("full_head0", 64'(out_flit[0 +: DW]), 64'h10);
        drive(0, DW'(8'h15), 1'b0, 1'b1);
        out_ready[0] = 1'b1;
        cycle();
        chk("full_pop_no_push", 64'(occupancy[0 +: OW]), 64'd3);
        cycle();
        drain();

        // Streaming on ch2
        out_ready[2] = 1'b1;
        drive(2, DW'(8'hA1), 1'b1, 1'b0);
        cycle();
        chk("stream_no_bypass", 64'(out_flit[2*DW +: DW]), 64'hA1);
        drive(2, DW'(8'hA2), 1'b0, 1'b0);
        cycle();
        chk("stream_occ_a2", 64'(occupancy[2*OW +: OW]), 64'd1);
        chk("stream_flit_a2", 64'(out_flit[2*DW +: DW]), 64'hA2);
        drive(2, DW'(8'hA3), 1'b0, 1'b1);
        cycle();
        chk("stream_occ_a3", 64'(occupancy[2*OW +: OW]), 64'd1);
        chk("stream_flit_a3", 64'(out_flit[2*DW +: DW]), 64'hA3);
        chk("stream_tail_a3", 64'(out_is_tail[2]), 64'd1);
        drain();

        // Wrap test on ch0
        idx = 0;
        got.delete();
        for (int cyc = 0; cyc < 200 && (idx < 10 || mq[0].size() != 0); cyc++) begin
            in_valid[0] = (idx < 10);
            if (idx < 10) drive(0, DW'(idx), idx == 0, idx == 9);
            out_ready[0] = 1'($urandom_range(0, 1));
            if (out_valid[0] && out_ready[0]) got.push_back({out_is_tail[0], out_flit[0 +: DW]});
            if (in_valid[0] && in_ready[0]) idx++;
            cycle();
        end
        chk("wrap_count", 64'(got.size()), 64'd10);
        for (int i = 0; i < got.size(); i++) begin
            chk($sformatf("wrap_flit%0d", i), 64'(got[i][DW-1:0]), 64'(i));
            chk($sformatf("wrap_tail%0d", i), 64'(got[i][DW]), 64'(i == 9));
        end
        drain();

        // Framing checker on ch1
        err_clr = '1;
        cycle();
        err_clr = '0;
        drive(1, DW'(8'h31), 1'b1, 1'b0);
        cycle();
        drive(1, DW'(8'h32), 1'b1, 1'b1);
        cycle();
        idle_inputs();
        chk("err_hdr_hdr", 64'(proto_err[1]), 64'(ERR_EN));
        cycle();
        chk("err_sticky", 64'(proto_err[1]), 64'(ERR_EN));
        err_clr[1] = 1'b1;
        cycle();
        err_clr[1] = 1'b0;
        chk("err_cleared", 64'(proto_err[1]), 64'd0);
        drive(1, DW'(8'h33), 1'b1, 1'b1);
        cycle();
        idle_inputs();
        cycle();
        chk("err_single_ok", 64'(proto_err), 64'd0);
        drain();

        // Asynchronous reset mid-packet with 3 flits on ch3
        for (int i = 0; i < 3; i++) begin
            drive(3, DW'(8'h40 + i), i == 0, 1'b0);
            cycle();
        end
        idle_inputs();
        #2 noc_rst = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        model_reset();
        #3 noc_rst = 1'b0;
        @(posedge noc_clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'hF);
        check_outputs();

        // Randomised traffic on all channels
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int c = 0; c < CH; c++) begin
                in_valid[c]         = 1'($urandom_range(0, 1));
                in_flit[c*DW +: DW] = DW'($urandom);
                in_is_header[c]     = ($urandom_range(0, 3) == 0);
                in_is_tail[c]       = ($urandom_range(0, 3) == 0);
                out_ready[c]        = 1'($urandom_range(0, 1));
                err_clr[c]          = ($urandom_range(0, 7) == 0);
            end
            cycle();
        end
        idle_inputs();
        check_outputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
